uart_tx_arbiter: RTL

- Shares one UART transmitter between four byte-stream requesters, e.g. board renderer, status reporter, echo path and debug dump.
- Grants the transmitter round-robin for a whole packet, which ends at the byte flagged last.
- Sequences each byte into the transmitter with a start/ready handshake.
- Revokes a stalled grant after a timeout so one requester cannot lock the serial line.

---
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART transmitter among four requesters
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              abort,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT, HOLD, SEND} state_t;
  state_t          state_q, state_d;
  logic [1:0]      g_q, g_d, pick;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            tx_start_q, tx_start_d, abort_q, abort_d, was_last_q, was_last_d, any;
  // g_q doubles as last_grant while idle; scanning from the far end lets the nearest requester win
  always_comb begin
    pick = g_q;
    any  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[g_q + 2'(k)]) begin
        pick = g_q + 2'(k);
        any  = 1'b1;
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    was_last_d  = was_last_q;
    tx_start_d  = 1'b0;
    abort_d     = 1'b0;
    req_ready_d = '0;
    case (state_q)
      IDLE: begin
        if (any) begin
          g_d     = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (tx_ready && req_valid[g_q]) begin
          tx_data_d   = req_data[{g_q, 3'b000} +: 8];
          tx_start_d  = 1'b1;
          req_ready_d = NREQ'(1) << g_q;
          was_last_d  = req_last[g_q];
          cnt_d       = '0;
          state_d     = HOLD;
        end else if (tx_ready) begin
          abort_d = cnt_q == CW'(TIMEOUT - 1);
          cnt_d   = abort_d ? cnt_q : cnt_q + 1'b1;
          state_d = abort_d ? IDLE : GRANT;
        end
      end
      HOLD: state_d = SEND;
      SEND: state_d = !tx_ready ? SEND : was_last_q ? IDLE : GRANT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      g_q         <= 2'd3;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      abort_q     <= 1'b0;
      req_ready_q <= '0;
      was_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      abort_q     <= abort_d;
      req_ready_q <= req_ready_d;
      was_last_q  <= was_last_d;
    end
  end
  assign grant     = (state_q == IDLE) ? '0 : NREQ'(1) << g_q;
  assign busy      = state_q != IDLE;
  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign abort     = abort_q;
endmodule
